// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
package arbiter_pkg;

  localparam int DEFAULT_NUM_PORTS = 6;
  localparam int DEFAULT_WEIGHT_W  = 4;

  // Ceiling log2, floored at 1 so a select field is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/arbiter_wrr_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after pointer,
// wrapping exactly modulo NUM_PORTS.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int ID_W      = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [ID_W-1:0]      pointer,
  output logic                 found,
  output logic [ID_W-1:0]      idx,
  output logic [NUM_PORTS-1:0] onehot
);

  // One extra bit holds pointer+offset (at most 2*NUM_PORTS-2) before the wrap.
  logic [ID_W:0]   cand_ext;
  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    found    = 1'b0;
    idx      = '0;
    onehot   = '0;
    cand_ext = '0;
    cand     = '0;
    // Walk offsets from farthest to nearest so the nearest requester is written last.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand_ext = {1'b0, pointer} + (ID_W+1)'(k);
      if (cand_ext >= (ID_W+1)'(NUM_PORTS)) begin
        cand_ext = cand_ext - (ID_W+1)'(NUM_PORTS);
      end
      cand = cand_ext[ID_W-1:0];
      if (request[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: an owner keeps the grant for its quantum of beats,
// or indefinitely while locked, then hands off to the next requester with no bubble.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int WEIGHT_W  = DEFAULT_WEIGHT_W,
  parameter int ID_W      = clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active
);

  logic [ID_W-1:0]      pointer_q, pointer_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic                 valid_q, valid_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;

  logic [WEIGHT_W-1:0]  weight_arr [NUM_PORTS];
  logic [ID_W-1:0]      next_ptr, pick_ptr, pick_idx;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic                 pick_found, done;

  function automatic logic [WEIGHT_W-1:0] quantum(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // The single picker serves idle arbitration and the look-ahead hand-off;
  // on hand-off it searches from the port after the retiring owner.
  assign next_ptr = (owner_q == ID_W'(NUM_PORTS - 1)) ? '0 : owner_q + ID_W'(1);
  assign pick_ptr = valid_q ? next_ptr : pointer_q;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_pick (
    .request (request),
    .pointer (pick_ptr),
    .found   (pick_found),
    .idx     (pick_idx),
    .onehot  (pick_onehot)
  );

  assign done = ~request[owner_q] | ((credit_q == WEIGHT_W'(1)) & ~lock[owner_q]);

  always_comb begin
    pointer_d = pointer_q;
    owner_d   = owner_q;
    credit_d  = credit_q;
    valid_d   = valid_q;
    grant_d   = grant_q;
    if (!valid_q) begin
      if (pick_found) begin
        owner_d  = pick_idx;
        credit_d = quantum(weight_arr[pick_idx]);
        valid_d  = 1'b1;
        grant_d  = pick_onehot;
      end
    end else if (!done) begin
      if (!lock[owner_q]) begin
        credit_d = credit_q - WEIGHT_W'(1);
      end
    end else begin
      pointer_d = next_ptr;
      if (pick_found) begin
        owner_d  = pick_idx;
        credit_d = quantum(weight_arr[pick_idx]);
        grant_d  = pick_onehot;
      end else begin
        credit_d = '0;
        valid_d  = 1'b0;
        grant_d  = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pointer_q <= '0;
      owner_q   <= '0;
      credit_q  <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
    end else begin
      pointer_q <= pointer_d;
      owner_q   <= owner_d;
      credit_q  <= credit_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = owner_q;
  assign active   = valid_q;

endmodule
